// File: rtl/out_port_pkg.sv
// Shared types for the handshaked output port: handshake FSM states and default buffer depth.
package out_port_pkg;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } hs_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while empty are ignored.
import out_port_pkg::*;

module sync_fifo #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // storage carries no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/output_port_hs.sv
// CPU output port: buffers bus writes and delivers them to a device over a four-phase valid/ack handshake.
import out_port_pkg::*;

module output_port_hs #(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [31:0]             busMuxOut,
  input  logic                    outPortIn,
  input  logic                    ovfClr,
  input  logic                    outAck,
  output logic [31:0]             outputUnit,
  output logic                    outValid,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);
  hs_state_t   state;
  logic [31:0] head;
  logic        pop;

  assign pop = (state == IDLE) && !empty;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (outPortIn),
    .pop   (pop),
    .wdata (busMuxOut),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      outputUnit <= '0;
      outValid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          outputUnit <= head;
          outValid   <= 1'b1;
          state      <= PRESENT;
        end
        PRESENT: if (outAck) begin
          outValid <= 1'b0;
          state    <= RELEASE;
        end
        RELEASE: if (!outAck) state <= IDLE;
        default: begin
          outValid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // a dropped write wins over a simultaneous clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                   overflow <= 1'b0;
    else if (outPortIn && full) overflow <= 1'b1;
    else if (ovfClr)            overflow <= 1'b0;
  end
endmodule

// File: tb/tb_output_port_hs.sv
// Scoreboard bench for output_port_hs: directed handshake/overflow/reset cases plus a random stream.
module tb_output_port_hs;
  localparam int DEPTH = 4;

  logic        clk, clr;
  logic [31:0] busMuxOut;
  logic        outPortIn, ovfClr, outAck;
  logic [31:0] outputUnit;
  logic        outValid, full, empty, overflow;
  logic [2:0]  count;

  output_port_hs #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .busMuxOut(busMuxOut), .outPortIn(outPortIn),
    .ovfClr(ovfClr), .outAck(outAck), .outputUnit(outputUnit), .outValid(outValid),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  bit lossy = 0, rnd_mode = 0, auto_ack = 0;
  int delivered = 0, skipped = 0, ovf_ev = 0, cnt_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: compares every newly presented word against the scoreboard
  initial begin
    bit prev_v = 0;
    forever begin
      @(posedge clk);
      #2;
      if (outValid && !prev_v) begin
        if (lossy)
          while (exp_q.size() > 0 && exp_q[0] !== outputUnit) begin
            void'(exp_q.pop_front());
            skipped++;
          end
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL word_unexpected: got %0h expected no word", outputUnit);
        end else begin
          chk("word", outputUnit, exp_q.pop_front());
          delivered++;
        end
      end
      prev_v = outValid;
      if (rnd_mode && overflow) ovf_ev++;
      if (rnd_mode && count > 3'(DEPTH)) cnt_bad++;
    end
  end

  // random four-phase responder for the stream phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_ack) begin
        if (outValid && !outAck && $urandom_range(0, 2) == 0) outAck = 1'b1;
        else if (outAck && !outValid && $urandom_range(0, 2) == 0) outAck = 1'b0;
      end
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (!outValid && n < 20) begin
      tick();
      n++;
    end
    if (!outValid) chk("valid_timeout", 32'(outValid), 32'd1);
  endtask

  task automatic deliver(input int n);
    for (int k = 0; k < n; k++) begin
      wait_valid();
      outAck = 1'b1;
      tick();
      outAck = 1'b0;
      tick();
    end
  endtask

  initial begin
    int nwr;
    clr = 1'b1; busMuxOut = '0; outPortIn = 0; ovfClr = 0; outAck = 0;
    #2 clr = 1'b0;
    #10;
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_unit", outputUnit, 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    tick(); tick();
    clr = 1'b1;
    tick();

    // single word latency
    exp_q.push_back(32'hDEADBEEF);
    outPortIn = 1; busMuxOut = 32'hDEADBEEF;
    tick();
    outPortIn = 0;
    chk("lat_valid_e1", 32'(outValid), 32'd0);
    chk("lat_count_e1", 32'(count), 32'd1);
    tick();
    chk("lat_valid_e2", 32'(outValid), 32'd1);
    chk("lat_unit_e2", outputUnit, 32'hDEADBEEF);
    chk("lat_count_e2", 32'(count), 32'd0);
    outAck = 1; tick();
    chk("lat_ack_drop", 32'(outValid), 32'd0);
    outAck = 0; tick(); tick();

    // long ack hold: next word only after ack released
    exp_q.push_back(32'hA0A0_0001);
    exp_q.push_back(32'hB0B0_0002);
    outPortIn = 1; busMuxOut = 32'hA0A0_0001; tick();
    busMuxOut = 32'hB0B0_0002; tick();
    outPortIn = 0;
    chk("hold_valid", 32'(outValid), 32'd1);
    chk("hold_unit", outputUnit, 32'hA0A0_0001);
    outAck = 1; tick();
    chk("hold_fall", 32'(outValid), 32'd0);
    tick(); tick(); tick();
    chk("hold_release_valid", 32'(outValid), 32'd0);
    chk("hold_release_unit", outputUnit, 32'hA0A0_0001);
    chk("hold_release_count", 32'(count), 32'd1);
    outAck = 0; tick();
    chk("hold_idle_valid", 32'(outValid), 32'd0);
    tick();
    chk("hold_next_valid", 32'(outValid), 32'd1);
    chk("hold_next_unit", outputUnit, 32'hB0B0_0002);
    outAck = 1; tick(); outAck = 0; tick(); tick();
    chk("hold_empty", 32'(empty), 32'd1);

    // fill to full, drop 0x6
    for (int k = 1; k <= 5; k++) exp_q.push_back(32'(k));
    for (int k = 1; k <= 6; k++) begin
      outPortIn = 1; busMuxOut = 32'(k); tick();
    end
    outPortIn = 0;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_unit", outputUnit, 32'd1);

    // write while full on the same edge as a pop
    outAck = 1; ovfClr = 1; tick();
    chk("ovf_cleared", 32'(overflow), 32'd0);
    outAck = 0; ovfClr = 0; tick();
    outPortIn = 1; busMuxOut = 32'h77; tick();
    outPortIn = 0;
    chk("poppush_ovf", 32'(overflow), 32'd1);
    chk("poppush_count", 32'(count), 32'(DEPTH - 1));
    chk("poppush_unit", outputUnit, 32'd2);
    exp_q.push_back(32'h8);
    outPortIn = 1; busMuxOut = 32'h8; ovfClr = 1; tick();
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("refill_full", 32'(full), 32'd1);
    busMuxOut = 32'h99; tick();
    chk("clr_vs_drop_ovf", 32'(overflow), 32'd1);
    outPortIn = 0; tick();
    chk("clr_ovf2", 32'(overflow), 32'd0);
    ovfClr = 0;
    deliver(5);
    tick();
    chk("fill_drained", 32'(exp_q.size()), 32'd0);
    chk("fill_empty", 32'(empty), 32'd1);

    // async reset while presenting with two words buffered
    exp_q.push_back(32'hC1);
    for (int k = 1; k <= 3; k++) begin
      outPortIn = 1; busMuxOut = 32'hC0 + 32'(k); tick();
    end
    outPortIn = 0;
    chk("pre_rst_count", 32'(count), 32'd2);
    #3 clr = 1'b0;
    #1;
    chk("arst_valid", 32'(outValid), 32'd0);
    chk("arst_unit", outputUnit, 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    tick();
    clr = 1'b1;
    repeat (6) tick();
    chk("arst_no_repr", 32'(outValid), 32'd0);
    chk("arst_sb", 32'(exp_q.size()), 32'd0);

    // random stream, ovfClr held so overflow mirrors each drop edge
    lossy = 1; ovfClr = 1; auto_ack = 1; delivered = 0;
    tick();
    rnd_mode = 1;
    nwr = 0;
    while (nwr < 1000) begin
      outPortIn = 1'($urandom_range(0, 1));
      if (outPortIn) begin
        busMuxOut = {16'(nwr), 16'($urandom)};
        exp_q.push_back(busMuxOut);
        nwr++;
      end
      tick();
    end
    outPortIn = 0;
    begin
      int n = 0;
      while ((!empty || outValid || outAck) && n < 5000) begin
        tick();
        n++;
      end
      if (!empty || outValid || outAck) chk("rnd_drain_timeout", 32'd1, 32'd0);
    end
    repeat (3) tick();
    chk("rnd_accounting", 32'(delivered + ovf_ev), 32'(nwr));
    chk("rnd_drops_match", 32'(skipped + exp_q.size()), 32'(ovf_ev));
    chk("rnd_drops_seen", 32'(ovf_ev > 0), 32'd1);
    chk("rnd_count_range", 32'(cnt_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
